// File: rtl/varredura_matriz.sv
// Row-scan controller for a 7x5 LED matrix: row index, active-low row drive,
// registered column drive with a blank cycle between rows, and frame selection.
module varredura_matriz #(
  parameter int DIV_MAX           = 50000,
  parameter int N_QUADROS         = 4,
  parameter int VARREDURAS_QUADRO = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       habilita,
  input  logic       modo_auto,
  input  logic       botao_avanco,
  input  logic [4:0] colunas_in,
  output logic [2:0] contador,
  output logic [6:0] linhas,
  output logic [4:0] colunas_out,
  output logic [1:0] quadro_sel,
  output logic       fim_quadro
);

  localparam int PW = $clog2(DIV_MAX);
  localparam int SW = $clog2(VARREDURAS_QUADRO + 1);

  typedef enum logic [1:0] {PARADO, APAGADO, EXIBE} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      cont_reg, cont_next;
  logic [PW-1:0]   presc_reg, presc_next;
  logic [SW-1:0]   scan_reg, scan_next;
  logic [1:0]      quadro_reg, quadro_next;
  logic [4:0]      col_reg, col_next;
  logic            fim_reg, fim_next;
  logic            btn_reg;

  logic            btn_edge;
  logic            presc_max;
  logic [1:0]      quadro_inc;
  logic [SW-1:0]   scan_inc;

  assign btn_edge   = botao_avanco & ~btn_reg;
  assign presc_max  = (presc_reg == PW'(DIV_MAX - 1));
  assign quadro_inc = (quadro_reg == 2'(N_QUADROS - 1)) ? 2'd0 : quadro_reg + 2'(1);
  assign scan_inc   = scan_reg + SW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= PARADO;
      cont_reg   <= 3'd0;
      presc_reg  <= '0;
      scan_reg   <= '0;
      quadro_reg <= 2'd0;
      col_reg    <= 5'd0;
      fim_reg    <= 1'b0;
      btn_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cont_reg   <= cont_next;
      presc_reg  <= presc_next;
      scan_reg   <= scan_next;
      quadro_reg <= quadro_next;
      col_reg    <= col_next;
      fim_reg    <= fim_next;
      btn_reg    <= botao_avanco;
    end
  end

  // Priority: display off, then button, then the normal scan sequence.
  always_comb begin
    state_next  = state_reg;
    cont_next   = cont_reg;
    presc_next  = presc_reg;
    scan_next   = scan_reg;
    quadro_next = quadro_reg;
    fim_next    = 1'b0;

    if (!habilita) begin
      state_next = PARADO;
      cont_next  = 3'd0;
      presc_next = '0;
      scan_next  = '0;
      if (btn_edge) quadro_next = quadro_inc;
    end else if (btn_edge) begin
      quadro_next = quadro_inc;
      state_next  = APAGADO;
      cont_next   = 3'd0;
      presc_next  = '0;
      scan_next   = '0;
    end else begin
      case (state_reg)
        PARADO: begin
          state_next = APAGADO;
          cont_next  = 3'd0;
          presc_next = '0;
        end
        APAGADO: begin
          state_next = EXIBE;
          presc_next = '0;
        end
        EXIBE: begin
          if (presc_max) begin
            state_next = APAGADO;
            presc_next = '0;
            if (cont_reg == 3'd6) begin
              cont_next = 3'd0;
              fim_next  = 1'b1;
              if (scan_inc == SW'(VARREDURAS_QUADRO)) begin
                quadro_next = quadro_inc;
                scan_next   = '0;
              end else begin
                scan_next = scan_inc;
              end
            end else begin
              cont_next = cont_reg + 3'(1);
            end
          end else begin
            presc_next = presc_reg + PW'(1);
          end
        end
        default: state_next = PARADO;
      endcase
    end

    if (!modo_auto) scan_next = '0;

    // Columns are loaded one cycle ahead so they line up with the lit row.
    col_next = (state_next == EXIBE) ? colunas_in : 5'd0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_linhas
      assign linhas[gi] = !((state_reg == EXIBE) && (cont_reg == 3'(gi)));
    end
  endgenerate

  assign contador    = cont_reg;
  assign colunas_out = col_reg;
  assign quadro_sel  = quadro_reg;
  assign fim_quadro  = fim_reg;

endmodule

// File: tb/tb_varredura_matriz.sv
// Bench for varredura_matriz: directed scenarios plus randomized run against a
// tick-based reference model of the row scan.
module tb_varredura_matriz;
  localparam int DIV_MAX = 4;
  localparam int NQ      = 4;
  localparam int VQ      = 2;

  logic       clk = 1'b0;
  logic       reset, habilita, modo_auto, botao_avanco;
  logic [4:0] colunas_in;
  logic [2:0] contador;
  logic [6:0] linhas;
  logic [4:0] colunas_out;
  logic [1:0] quadro_sel;
  logic       fim_quadro;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a row is a run of DIV_MAX+1 ticks, tick 0 being the blank.
  bit m_run;
  int m_row, m_tick, m_frame, m_scans;
  bit m_btn_prev, m_fim;
  logic [4:0] m_col;

  varredura_matriz #(.DIV_MAX(DIV_MAX), .N_QUADROS(NQ), .VARREDURAS_QUADRO(VQ)) dut (
    .clk(clk), .reset(reset), .habilita(habilita), .modo_auto(modo_auto),
    .botao_avanco(botao_avanco), .colunas_in(colunas_in), .contador(contador),
    .linhas(linhas), .colunas_out(colunas_out), .quadro_sel(quadro_sel),
    .fim_quadro(fim_quadro)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    bit edge_b;
    if (reset) begin
      m_run = 0; m_row = 0; m_tick = 0; m_frame = 0; m_scans = 0;
      m_btn_prev = 0; m_fim = 0; m_col = 5'd0;
      return;
    end
    edge_b = botao_avanco && !m_btn_prev;
    m_btn_prev = botao_avanco;
    m_fim = 0;
    if (!habilita) begin
      if (edge_b) m_frame = (m_frame + 1) % NQ;
      m_run = 0; m_row = 0; m_tick = 0; m_scans = 0;
    end else if (edge_b) begin
      m_frame = (m_frame + 1) % NQ;
      m_run = 1; m_row = 0; m_tick = 0; m_scans = 0;
    end else if (!m_run) begin
      m_run = 1; m_row = 0; m_tick = 0;
    end else if (m_tick < DIV_MAX) begin
      m_tick++;
    end else begin
      m_tick = 0;
      if (m_row == 6) begin
        m_row = 0;
        m_fim = 1;
        m_scans++;
        if (m_scans == VQ) begin
          m_frame = (m_frame + 1) % NQ;
          m_scans = 0;
        end
      end else begin
        m_row++;
      end
    end
    if (!modo_auto) m_scans = 0;
    m_col = (m_run && m_tick != 0) ? colunas_in : 5'd0;
  endtask

  task automatic step();
    logic [6:0] exp_lin;
    @(posedge clk);
    model_update();
    #1;
    exp_lin = (m_run && m_tick != 0) ? ~(7'd1 << m_row) : 7'h7F;
    chk("contador", 32'(contador), 32'(m_row));
    chk("linhas", 32'(linhas), 32'(exp_lin));
    chk("colunas_out", 32'(colunas_out), 32'(m_col));
    chk("quadro_sel", 32'(quadro_sel), 32'(m_frame));
    chk("fim_quadro", 32'(fim_quadro), 32'(m_fim));
  endtask

  task automatic wait_row(input int row, output bit found);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_run && m_row == row && m_tick == 2) found = 1;
      else step();
    end
  endtask

  initial begin
    int  wraps;
    bit  found;
    logic [1:0] q0;

    reset = 1; habilita = 0; modo_auto = 0; botao_avanco = 0; colunas_in = 5'h15;
    step(); step();
    chk("rst_linhas", 32'(linhas), 32'h7F);
    chk("rst_cont", 32'(contador), 32'd0);
    chk("rst_col", 32'(colunas_out), 32'd0);
    chk("rst_quadro", 32'(quadro_sel), 32'd0);
    $display("reset: linhas=%h contador=%0d quadro=%0d", linhas, contador, quadro_sel);

    // Startup timing and auto frame advance
    reset = 0; habilita = 1; modo_auto = 1;
    step();
    chk("start_blank", 32'(linhas), 32'h7F);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("start_row0", 32'(linhas), 32'h7E);
      chk("start_col", 32'(colunas_out), 32'h15);
    end
    wraps = 0;
    for (int i = 0; i < 400 && wraps < 8; i++) begin
      step();
      if (fim_quadro) begin
        wraps++;
        if (wraps == 2) chk("auto_q_after2", 32'(quadro_sel), 32'd1);
      end
    end
    chk("auto_wraps", 32'(wraps), 32'd8);
    chk("auto_q_after8", 32'(quadro_sel), 32'd0);
    $display("auto: wraps=%0d quadro=%0d", wraps, quadro_sel);

    // Button held mid row 3
    wait_row(3, found);
    chk("btn_wait", 32'(found), 32'd1);
    q0 = quadro_sel;
    botao_avanco = 1;
    step();
    chk("btn_cont", 32'(contador), 32'd0);
    chk("btn_blank", 32'(linhas), 32'h7F);
    for (int i = 0; i < 9; i++) step();
    chk("btn_once", 32'(quadro_sel), 32'(q0 + 2'd1));
    botao_avanco = 0;
    $display("button: quadro %0d -> %0d", q0, quadro_sel);

    // Disable mid row 4
    wait_row(4, found);
    chk("dis_wait", 32'(found), 32'd1);
    q0 = quadro_sel;
    habilita = 0;
    step();
    chk("dis_linhas", 32'(linhas), 32'h7F);
    chk("dis_col", 32'(colunas_out), 32'd0);
    chk("dis_cont", 32'(contador), 32'd0);
    chk("dis_quadro", 32'(quadro_sel), 32'(q0));
    for (int i = 0; i < 5; i++) step();
    $display("disable: linhas=%h quadro=%0d", linhas, quadro_sel);

    // Randomized run
    habilita = 1;
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom % 300) == 0;
      if (($urandom % 60) == 0) habilita = ~habilita;
      else if (!habilita && ($urandom % 8) == 0) habilita = 1;
      if (($urandom % 150) == 0) modo_auto = ~modo_auto;
      if (($urandom % 25) == 0) botao_avanco = ~botao_avanco;
      colunas_in = 5'($urandom);
      step();
    end
    $display("random: 4000 cycles done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
